// File: rtl/ps2_keycode_fifo.sv
// Buffers scan codes from the KFPS2KB receiver in a small FIFO and presents them
// to the XT-side port logic over valid/ready, counting codes lost to overflow.
module ps2_keycode_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  kb_irq,
  input  logic [7:0]            kb_keycode,
  output logic                  kb_clear_keycode,
  output logic                  out_valid,
  output logic [7:0]            out_keycode,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  input  logic                  overflow_clear
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, ACK} state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  capture;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign full        = (fill_count == (DEPTH_LOG2+1)'(DEPTH));
  assign out_valid   = (fill_count != '0);
  assign out_keycode = out_valid ? mem[rd_ptr] : 8'h00;
  assign pop         = out_valid && out_ready;
  assign capture     = (state == IDLE) && kb_irq;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push        = capture && (!full || pop);
  assign drop        = capture && full && !pop;

  // Capture handshake: one push or drop per irq assertion, ack held until irq falls.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      kb_clear_keycode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (kb_irq) begin
            state            <= ACK;
            kb_clear_keycode <= 1'b1;
          end
        end
        ACK: begin
          if (!kb_irq) begin
            state            <= IDLE;
            kb_clear_keycode <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          kb_clear_keycode <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (push) mem[wr_ptr] <= kb_keycode;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   fill_count <= fill_count + (DEPTH_LOG2+1)'(1);
        2'b01:   fill_count <= fill_count - (DEPTH_LOG2+1)'(1);
        default: fill_count <= fill_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, leaving a count of one.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clear)
        drop_count <= DROP_CNT_W'(1);
      else if (drop_count != '1)
        drop_count <= drop_count + DROP_CNT_W'(1);
    end else if (overflow_clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule
